cvxif_vec_sequencer: RTL and testbench
======================================

# cvxif_vec_sequencer

Sequencer for the CV-X-IF example coprocessor's custom vector instructions. It sits behind the issue-stage predecoder and queues accepted instructions until the core commits or kills them. Committed instructions are expanded into one lane command per element, `vlen` commands in total. When a writeback is required, a single result is returned on the X-interface result channel.

## Interface
Parameters:
- `QueueDepth`, 4: outstanding accepted instructions; power of two, ≥2.
- `IdWidth`, `cvxif_pkg::X_ID_WIDTH`: instruction id width.
- `XLen`, 32: operand/result width.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  reset; **synchronous, active-low**.
- `issue_valid_i`  in  1  issue request valid, already qualified by predecoder `accept`.
- `issue_ready_o`  out  1  queue not full.
- `issue_id_i`  in  IdWidth  instruction id.
- `issue_rs1_i`  in  XLen  scalar operand.
- `issue_op_i`  in  `custom_vec_op_e`  decoded op.
- `issue_vlen_i`  in  `vlen_t`  decoded element count.
- `issue_wb_i`  in  1  decoded writeback flag.
- `commit_valid_i`  in  1  commit event.
- `commit_id_i`  in  IdWidth  committed id.
- `commit_kill_i`  in  1  1 means kill, 0 means commit.
- `elem_valid_o`  out  1  lane command valid; there is no backpressure.
- `elem_idx_o`  out  `vlen_t`  element index.
- `elem_op_o`  out  `custom_vec_op_e`  lane op.
- `elem_opnd_o`  out  XLen  rs1 operand.
- `result_valid_o`  out  1  result valid.
- `result_ready_i`  in  1  result accepted.
- `result_id_o`  out  IdWidth  result id.
- `result_data_o`  out  XLen  result data, which is the rs1 operand.
- `busy_o`  out  1  queue non-empty or FSM not IDLE.

## Operation
- **Queue.**
  - Circular FIFO with read and write pointers one bit wider than the index.
  - Each entry holds {id, rs1, op, vlen, wb, committed, killed}.
  - Enqueue on `issue_valid_i & issue_ready_o`.
- **Commit.**
  - Every valid entry whose id equals `commit_id_i` sets `committed`, or sets `killed` when `commit_kill_i`=1.
  - A commit in the same cycle as the enqueue of that id applies to the new entry.
  - A commit matching no entry is ignored.
- **FSM states:** IDLE, EXEC, RESULT.
  - IDLE, head valid and killed: pop, stay in IDLE.
  - IDLE, head valid and committed: latch head into the working registers, pop, clear the element counter, go to EXEC.
  - IDLE, otherwise: wait.
  - EXEC: `elem_valid_o`=1 each cycle with `elem_idx_o` = counter; increment the counter.
  - EXEC, on the cycle with counter = eff_vlen−1: go to RESULT if wb, else IDLE.
  - eff_vlen = max(vlen, 1); vlen=0 issues exactly one element.
  - RESULT: hold `result_valid_o`=1 with stable id/data until `result_ready_i`, then go to IDLE.
- **Ordering.** Strictly in order. A killed entry behind an uncommitted head waits.
- **Arithmetic.** The element counter is `vlen_t` width, with no wrap inside one instruction.
- **Pointers.** Wrap modulo QueueDepth. Full = indices equal and MSBs differ.

## Timing
- **Reset values:**
  - `issue_ready_o`=1.
  - `busy_o`, `elem_valid_o`, `result_valid_o` = 0.
  - Pointers and all entry flags cleared.
  - FSM in IDLE.
  - Data outputs = 0.
- **Reset mid-operation.** Drops all queued and in-flight instructions. No result is produced.
- **Issue path.**
  - `issue_ready_o` is registered-state combinational (depends only on the pointers).
  - A pop in the same cycle does not free a slot until the next cycle.
- **Latency.** Head committed at cycle t (flag visible): first `elem_valid_o` at t+1, last at t+eff_vlen, `result_valid_o` from t+eff_vlen+1.
- **Commit timing.** A commit arriving in the same cycle as the head is examined takes effect the next cycle.
- **Result channel.** Result valid/ready follow X-interface rules: valid is never dropped without ready.

## Configuration
- **`CVXIF_SEQ_PERF_EN` defined:**
  - Adds outputs `perf_retired_o` (32, counts completed EXEC instructions) and `perf_killed_o` (32, counts killed pops).
  - Both counters saturate at all-ones and reset to 0.
- **Undefined:** the ports and counters are absent. Functional behaviour is identical.

## Structure
- **`cvxif_instr_pkg` holds:**
  - `seq_state_e`.
  - The queue entry struct `seq_entry_t`.
  - Reuse of `custom_vec_op_e` and `vlen_t`.
- **Sub-module `cvxif_seq_queue`:** FIFO storage plus commit/kill id matching. The FSM and element counter stay in the top module.

## Test plan
- **Single instruction:**
  - Stimulus: issue id=3, vlen=4, wb=1; commit id=3 one cycle later; `result_ready_i`=1.
  - Required: four `elem_valid_o` pulses with idx 0..3, then a one-cycle result with id=3, data=rs1.
- **Kill:** issue ids 1, 2; kill 1, commit 2 → id 1 produces no elements; id 2 executes.
- **Full queue:** 4 uncommitted issues → `issue_ready_o`=0. Commit the head → ready returns 1 the cycle after its pop.
- **Same-cycle commit:** issue and commit the same id in one cycle; vlen=0 → exactly one element (idx 0).
- **Backpressure:** `result_ready_i` low 5 cycles → `result_valid_o`, id and data stable; no new EXEC starts.
- **Reset mid-operation:** `rst_ni` low during EXEC at idx 2 → all outputs at reset values next cycle; queue empty.

Source files
------------

// File: rtl/cvxif_instr_pkg.sv
// Types shared by the custom vector instruction sequencer and its queue.
package cvxif_instr_pkg;

  localparam int unsigned SeqXLen   = 32;
  localparam int unsigned VlenWidth = 4;

  typedef logic [VlenWidth-1:0]              vlen_t;
  typedef logic [cvxif_pkg::X_ID_WIDTH-1:0]  seq_id_t;
  typedef logic [SeqXLen-1:0]                seq_xlen_t;

  typedef enum logic [1:0] {
    VEC_ADD,
    VEC_SUB,
    VEC_MUL,
    VEC_SPLAT
  } custom_vec_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_EXEC,
    SEQ_RESULT
  } seq_state_e;

  typedef struct packed {
    seq_id_t        id;
    seq_xlen_t      rs1;
    custom_vec_op_e op;
    vlen_t          vlen;
    logic           wb;
    logic           committed;
    logic           killed;
  } seq_entry_t;

  // A vlen of zero still issues one element.
  function automatic vlen_t last_elem_idx(input vlen_t vlen);
    return (vlen == '0) ? '0 : vlen - vlen_t'(1);
  endfunction

endpackage

// File: rtl/cvxif_pkg.sv
// Shared CV-X-IF interface constants used by the coprocessor blocks.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

endpackage

// File: rtl/cvxif_seq_queue.sv
// In-order queue of accepted vector instructions with commit/kill id matching.
module cvxif_seq_queue
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  seq_entry_t push_entry_i,
  input  logic       pop_i,
  input  logic       commit_valid_i,
  input  seq_id_t    commit_id_i,
  input  logic       commit_kill_i,
  output logic       full_o,
  output logic       empty_o,
  output seq_entry_t head_o
);

  localparam int unsigned AW = $clog2(Depth);
  typedef logic [AW:0] ptr_t;

  ptr_t             wptr_q, rptr_q, count;
  seq_entry_t       mem_q [Depth];
  logic [AW-1:0]    offset [Depth];
  logic [Depth-1:0] slot_valid, slot_hit;
  seq_entry_t       new_entry;
  logic             do_push, push_hit;

  assign count   = wptr_q - rptr_q;
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign push_hit = commit_valid_i && (commit_id_i == push_entry_i.id);

  // A commit in the enqueue cycle lands directly in the new entry's flags.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    new_entry           = push_entry_i;
    new_entry.committed = push_hit & ~commit_kill_i;
    new_entry.killed    = push_hit & commit_kill_i;
  end

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      offset[i]     = AW'(i) - rptr_q[AW-1:0];
      slot_valid[i] = ptr_t'({1'b0, offset[i]}) < count;
      slot_hit[i]   = slot_valid[i] && commit_valid_i && (mem_q[i].id == commit_id_i);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + ptr_t'(1);
      if (pop_i)   rptr_q <= rptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: only the flags are reset; payload fields are don't-care until a push writes them.
      for (int i = 0; i < Depth; i++) begin
        mem_q[i].committed <= 1'b0;
        mem_q[i].killed    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (slot_hit[i]) begin
          if (commit_kill_i) mem_q[i].killed    <= 1'b1;
          else               mem_q[i].committed <= 1'b1;
        end
      end
      if (do_push) mem_q[wptr_q[AW-1:0]] <= new_entry;
    end
  end

endmodule

// File: rtl/cvxif_vec_sequencer.sv
// Expands committed custom vector instructions into per-element lane commands.
// Define CVXIF_SEQ_PERF_EN to add saturating retired/killed performance counters.
module cvxif_vec_sequencer
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned IdWidth    = cvxif_pkg::X_ID_WIDTH,
  parameter int unsigned XLen       = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLen-1:0]    issue_rs1_i,
  input  custom_vec_op_e     issue_op_i,
  input  vlen_t              issue_vlen_i,
  input  logic               issue_wb_i,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               elem_valid_o,
  output vlen_t              elem_idx_o,
  output custom_vec_op_e     elem_op_o,
  output logic [XLen-1:0]    elem_opnd_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLen-1:0]    result_data_o,
  output logic               busy_o
`ifdef CVXIF_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_retired_o,
  output logic [31:0]        perf_killed_o
`endif
);

  seq_state_e     state_q, state_d;
  vlen_t          cnt_q;
  seq_id_t        w_id_q;
  seq_xlen_t      w_rs1_q;
  custom_vec_op_e w_op_q;
  vlen_t          w_vlen_q;
  logic           w_wb_q;
  seq_entry_t     head, push_entry;
  logic           full, empty, pop, start, kill_pop, last_elem;

  assign push_entry = '{id: issue_id_i, rs1: issue_rs1_i, op: issue_op_i, vlen: issue_vlen_i,
                        wb: issue_wb_i, committed: 1'b0, killed: 1'b0};

  cvxif_seq_queue #(.Depth(QueueDepth)) u_queue (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .push_i         (issue_valid_i),
    .push_entry_i   (push_entry),
    .pop_i          (pop),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .full_o         (full),
    .empty_o        (empty),
    .head_o         (head)
  );

  assign issue_ready_o = ~full;
  assign last_elem     = (cnt_q == last_elem_idx(w_vlen_q));
  assign busy_o        = ~empty | (state_q != SEQ_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= SEQ_IDLE;
      cnt_q    <= '0;
      w_id_q   <= '0;
      w_rs1_q  <= '0;
      w_op_q   <= VEC_ADD;
      w_vlen_q <= '0;
      w_wb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q    <= '0;
        w_id_q   <= head.id;
        w_rs1_q  <= head.rs1;
        w_op_q   <= head.op;
        w_vlen_q <= head.vlen;
        w_wb_q   <= head.wb;
      end else if (state_q == SEQ_EXEC) begin
        cnt_q <= cnt_q + vlen_t'(1);
      end
    end
  end

  // Kill takes priority if an id was both killed and committed.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    start    = 1'b0;
    kill_pop = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (!empty && head.killed) begin
          pop      = 1'b1;
          kill_pop = 1'b1;
        end else if (!empty && head.committed) begin
          pop     = 1'b1;
          start   = 1'b1;
          state_d = SEQ_EXEC;
        end
      end
      SEQ_EXEC:   if (last_elem) state_d = w_wb_q ? SEQ_RESULT : SEQ_IDLE;
      SEQ_RESULT: if (result_ready_i) state_d = SEQ_IDLE;
      default:    state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    elem_valid_o   = 1'b0;
    elem_idx_o     = '0;
    elem_op_o      = VEC_ADD;
    elem_opnd_o    = '0;
    result_valid_o = 1'b0;
    result_id_o    = '0;
    result_data_o  = '0;
    unique case (state_q)
      SEQ_EXEC: begin
        elem_valid_o = 1'b1;
        elem_idx_o   = cnt_q;
        elem_op_o    = w_op_q;
        elem_opnd_o  = w_rs1_q;
      end
      SEQ_RESULT: begin
        result_valid_o = 1'b1;
        result_id_o    = w_id_q;
        result_data_o  = w_rs1_q;
      end
      default: ;
    endcase
  end

`ifdef CVXIF_SEQ_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_retired_o <= '0;
      perf_killed_o  <= '0;
    end else begin
      if (state_q == SEQ_EXEC && last_elem && perf_retired_o != '1)
        perf_retired_o <= perf_retired_o + 32'd1;
      if (kill_pop && perf_killed_o != '1)
        perf_killed_o <= perf_killed_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cvxif_vec_sequencer.sv
// Directed self-checking bench for cvxif_vec_sequencer.
module tb_cvxif_vec_sequencer;
  import cvxif_instr_pkg::*;

  localparam int unsigned IdW = cvxif_pkg::X_ID_WIDTH;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           issue_valid_i;
  logic           issue_ready_o;
  logic [IdW-1:0] issue_id_i;
  logic [31:0]    issue_rs1_i;
  custom_vec_op_e issue_op_i;
  vlen_t          issue_vlen_i;
  logic           issue_wb_i;
  logic           commit_valid_i;
  logic [IdW-1:0] commit_id_i;
  logic           commit_kill_i;
  logic           elem_valid_o;
  vlen_t          elem_idx_o;
  custom_vec_op_e elem_op_o;
  logic [31:0]    elem_opnd_o;
  logic           result_valid_o;
  logic           result_ready_i;
  logic [IdW-1:0] result_id_o;
  logic [31:0]    result_data_o;
  logic           busy_o;
`ifdef CVXIF_SEQ_PERF_EN
  logic [31:0]    perf_retired_o, perf_killed_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  cvxif_vec_sequencer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_id_i     (issue_id_i),
    .issue_rs1_i    (issue_rs1_i),
    .issue_op_i     (issue_op_i),
    .issue_vlen_i   (issue_vlen_i),
    .issue_wb_i     (issue_wb_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .elem_valid_o   (elem_valid_o),
    .elem_idx_o     (elem_idx_o),
    .elem_op_o      (elem_op_o),
    .elem_opnd_o    (elem_opnd_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_data_o  (result_data_o),
    .busy_o         (busy_o)
`ifdef CVXIF_SEQ_PERF_EN
    ,
    .perf_retired_o (perf_retired_o),
    .perf_killed_o  (perf_killed_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic set_issue(input logic [IdW-1:0] id, input logic [31:0] rs1,
                           input custom_vec_op_e op, input vlen_t vlen, input logic wb);
    issue_valid_i = 1'b1;
    issue_id_i    = id;
    issue_rs1_i   = rs1;
    issue_op_i    = op;
    issue_vlen_i  = vlen;
    issue_wb_i    = wb;
  endtask

  task automatic set_commit(input logic [IdW-1:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    issue_id_i = '0; issue_rs1_i = '0; issue_op_i = VEC_ADD; issue_vlen_i = '0; issue_wb_i = 1'b0;
    commit_id_i = '0; result_ready_i = 1'b1;
    tick(); tick();
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", issue_ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (elem_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_elem_valid: got %b want 0", elem_valid_o); end
    n_cmp++; if (result_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_result_valid: got %b want 0", result_valid_o); end
    n_cmp++; if (elem_idx_o !== '0 || elem_opnd_o !== '0) begin n_bad++; $display("FAIL reset_elem_data: got idx %0h opnd %0h want 0", elem_idx_o, elem_opnd_o); end
    n_cmp++; if (result_id_o !== '0 || result_data_o !== '0) begin n_bad++; $display("FAIL reset_result_data: got id %0h data %0h want 0", result_id_o, result_data_o); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_issue(3, 32'hA5A5_0003, VEC_MUL, 4'd4, 1'b1);
    tick();
    idle_inputs();
    set_commit(3, 1'b0);
    tick();
    idle_inputs();
    n_cmp++; if (elem_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_not_early: got %b want 0", elem_valid_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (elem_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_elem_valid[%0d]: got %b want 1", i, elem_valid_o); end
      n_cmp++; if (elem_idx_o !== vlen_t'(i)) begin n_bad++; $display("FAIL single_elem_idx[%0d]: got %0d want %0d", i, elem_idx_o, i); end
      n_cmp++; if (elem_opnd_o !== 32'hA5A5_0003 || elem_op_o !== VEC_MUL) begin n_bad++; $display("FAIL single_elem_payload[%0d]: got %0h/%0d want a5a50003/%0d", i, elem_opnd_o, elem_op_o, VEC_MUL); end
      tick();
    end
    n_cmp++; if (elem_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_elem_stop: got %b want 0", elem_valid_o); end
    n_cmp++; if (result_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_result_valid: got %b want 1", result_valid_o); end
    n_cmp++; if (result_id_o !== 3 || result_data_o !== 32'hA5A5_0003) begin n_bad++; $display("FAIL single_result: got id %0h data %0h want 3/a5a50003", result_id_o, result_data_o); end
    tick();
    n_cmp++; if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL single_done: got valid %b busy %b want 0/0", result_valid_o, busy_o); end
  endtask

  task automatic test_kill();
    int n_elem = 0, n_res = 0, bad_opnd = 0;
    logic [IdW-1:0] res_id = '0;
    set_issue(1, 32'h111, VEC_ADD, 4'd3, 1'b1);
    tick();
    set_issue(2, 32'h222, VEC_SUB, 4'd2, 1'b1);
    tick();
    idle_inputs();
    set_commit(1, 1'b1);
    tick();
    set_commit(2, 1'b0);
    tick();
    idle_inputs();
    for (int c = 0; c < 12; c++) begin
      if (elem_valid_o) begin n_elem++; if (elem_opnd_o !== 32'h222) bad_opnd++; end
      if (result_valid_o) begin n_res++; res_id = result_id_o; end
      tick();
    end
    n_cmp++; if (n_elem !== 2) begin n_bad++; $display("FAIL kill_elem_count: got %0d want 2", n_elem); end
    n_cmp++; if (bad_opnd !== 0) begin n_bad++; $display("FAIL kill_elem_opnd: got %0d foreign elements want 0", bad_opnd); end
    n_cmp++; if (n_res !== 1 || res_id !== 2) begin n_bad++; $display("FAIL kill_result: got %0d results id %0h want 1 id 2", n_res, res_id); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL kill_idle: got %b want 0", busy_o); end
  endtask

  task automatic test_full();
    int n_elem = 0;
    for (int k = 4; k < 8; k++) begin
      set_issue(IdW'(k), 32'h400 + k, VEC_ADD, 4'd1, 1'b0);
      tick();
    end
    idle_inputs();
    n_cmp++; if (issue_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", issue_ready_o); end
    // Push attempt while full must be dropped; commit head in the same cycle.
    set_issue(12, 32'h40C, VEC_ADD, 4'd1, 1'b0);
    set_commit(4, 1'b0);
    tick();
    idle_inputs();
    n_cmp++; if (issue_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_ready_before_pop: got %b want 0", issue_ready_o); end
    tick();
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL full_ready_after_pop: got %b want 1", issue_ready_o); end
    n_cmp++; if (elem_valid_o !== 1'b1 || elem_opnd_o !== 32'h404) begin n_bad++; $display("FAIL full_head_exec: got %b/%0h want 1/404", elem_valid_o, elem_opnd_o); end
    for (int k = 5; k < 8; k++) begin
      set_commit(IdW'(k), 1'b1);
      tick();
    end
    set_commit(12, 1'b0);
    tick();
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      if (elem_valid_o) n_elem++;
      tick();
    end
    n_cmp++; if (n_elem !== 0) begin n_bad++; $display("FAIL full_dropped_push: got %0d elements want 0", n_elem); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL full_drain: got busy %b want 0", busy_o); end
  endtask

  task automatic test_same_cycle();
    int n_elem = 0, n_res = 0;
    vlen_t idx_seen = '1;
    set_issue(9, 32'h9999, VEC_SPLAT, 4'd0, 1'b0);
    set_commit(9, 1'b0);
    tick();
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      if (elem_valid_o) begin n_elem++; idx_seen = elem_idx_o; end
      if (result_valid_o) n_res++;
      tick();
    end
    n_cmp++; if (n_elem !== 1) begin n_bad++; $display("FAIL same_cycle_count: got %0d want 1", n_elem); end
    n_cmp++; if (idx_seen !== '0) begin n_bad++; $display("FAIL same_cycle_idx: got %0d want 0", idx_seen); end
    n_cmp++; if (n_res !== 0) begin n_bad++; $display("FAIL same_cycle_no_result: got %0d want 0", n_res); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    result_ready_i = 1'b0;
    set_issue(5, 32'hDEAD_BEEF, VEC_ADD, 4'd1, 1'b1);
    set_commit(5, 1'b0);
    tick();
    set_issue(6, 32'h66, VEC_SUB, 4'd2, 1'b0);
    set_commit(6, 1'b0);
    tick();
    idle_inputs();
    while (!result_valid_o && k < 10) begin tick(); k++; end
    n_cmp++; if (result_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_result_timeout: got %b want 1", result_valid_o); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (result_valid_o !== 1'b1 || result_id_o !== 5 || result_data_o !== 32'hDEAD_BEEF || elem_valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v%b id %0h data %0h elem %b want 1/5/deadbeef/0", c, result_valid_o, result_id_o, result_data_o, elem_valid_o);
      end
      tick();
    end
    result_ready_i = 1'b1;
    tick();
    n_cmp++; if (result_valid_o !== 1'b0 || elem_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_release: got v%b elem %b want 0/0", result_valid_o, elem_valid_o); end
    tick();
    n_cmp++; if (elem_valid_o !== 1'b1 || elem_idx_o !== 4'd0 || elem_opnd_o !== 32'h66) begin n_bad++; $display("FAIL bp_next_elem0: got %b/%0d/%0h want 1/0/66", elem_valid_o, elem_idx_o, elem_opnd_o); end
    tick();
    n_cmp++; if (elem_valid_o !== 1'b1 || elem_idx_o !== 4'd1) begin n_bad++; $display("FAIL bp_next_elem1: got %b/%0d want 1/1", elem_valid_o, elem_idx_o); end
    tick();
    n_cmp++; if (elem_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL bp_done: got elem %b busy %b want 0/0", elem_valid_o, busy_o); end
  endtask

  task automatic test_reset_mid();
    int k = 0, n_act = 0;
    set_issue(7, 32'h77, VEC_MUL, 4'd6, 1'b1);
    set_commit(7, 1'b0);
    tick();
    set_issue(8, 32'h88, VEC_ADD, 4'd2, 1'b1);
    set_commit(8, 1'b0);
    tick();
    idle_inputs();
    while (!(elem_valid_o && elem_idx_o == 4'd2) && k < 10) begin tick(); k++; end
    n_cmp++; if (elem_valid_o !== 1'b1 || elem_idx_o !== 4'd2) begin n_bad++; $display("FAIL rst_mid_reach_idx2: got %b/%0d want 1/2", elem_valid_o, elem_idx_o); end
    rst_ni = 1'b0;
    tick();
    n_cmp++;
    if (elem_valid_o !== 1'b0 || result_valid_o !== 1'b0 || busy_o !== 1'b0 || issue_ready_o !== 1'b1 ||
        elem_idx_o !== '0 || elem_opnd_o !== '0 || result_data_o !== '0 || result_id_o !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got ev%b rv%b busy%b rdy%b idx%0h opnd%0h want 0/0/0/1/0/0", elem_valid_o, result_valid_o, busy_o, issue_ready_o, elem_idx_o, elem_opnd_o);
    end
    rst_ni = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (elem_valid_o || result_valid_o || busy_o) n_act++;
      tick();
    end
    n_cmp++; if (n_act !== 0) begin n_bad++; $display("FAIL rst_mid_queue_empty: got %0d active cycles want 0", n_act); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_kill();
    test_full();
    test_same_cycle();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
